// File: rtl/join_match_memory.sv
`timescale 1ns/1ps
// join_match_memory
// 64-entry tag-matching operand store for a dataflow join. An incoming packet
// is held in P, compared against every valid entry for one cycle (CMP), and
// then acted upon (ACT) with the allocation controller's WR_E/DEL/ADDR.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a packet; accepts only if the result register is free
// CMP   | associative compare of P.TAG against all entries, FIRE/MF valid
// ACT   | pair (delete + emit), store (write), bypass (emit), or drop (OVF)
module join_match_memory #(
  parameter int TAG_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              IN_V,
  output logic              IN_RDY,
  input  logic              IN_MF,
  input  logic [TAG_W-1:0]  IN_TAG,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic [63:0]       FIRE,
  output logic [63:0]       VALID,
  output logic              MF,
  input  logic              WR_E,
  input  logic              DEL,
  input  logic [5:0]        ADDR,
  output logic              OUT_V,
  input  logic              OUT_RDY,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B,
  output logic              OUT_PAIR,
  output logic              OVF
);

  localparam int N = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_ACT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // packet-hold register P
  logic              p_mf_q, p_mf_d;
  logic [TAG_W-1:0]  p_tag_q, p_tag_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;

  // compare results captured at the CMP->ACT edge
  logic hit_q, hit_d;
  logic full_q, full_d;

  // entry storage; only occupancy is reset, VALID masks stale tag/data
  logic [N-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [N];
  logic [DATA_W-1:0] data_mem [N];
  logic              mem_we;

  // result register
  logic              out_v_q, out_v_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic              out_pair_q, out_pair_d;

  logic          in_rdy;
  logic [N-1:0]  fire;
  logic          ovf;

  // Accept only in IDLE when the result register is empty or drains this edge;
  // reset holds ready low even though the state already reads IDLE.
  assign in_rdy = !MR && (state_q == S_IDLE) && (!out_v_q || OUT_RDY);

  // Associative compare, only meaningful while P is being compared.
  always_comb begin
    fire = '0;
    if (state_q == S_CMP && p_mf_q) begin
      for (int i = 0; i < N; i++) begin
        fire[i] = valid_q[i] && (tag_mem[i] == p_tag_q);
      end
    end
  end

  // Next-state, datapath and single-cycle OVF decode.
  always_comb begin
    state_d    = state_q;
    p_mf_d     = p_mf_q;
    p_tag_d    = p_tag_q;
    p_data_d   = p_data_q;
    hit_d      = hit_q;
    full_d     = full_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    out_v_d    = out_v_q;
    out_tag_d  = out_tag_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_pair_d = out_pair_q;
    ovf        = 1'b0;

    if (out_v_q && OUT_RDY) begin
      out_v_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (IN_V && in_rdy) begin
          p_mf_d   = IN_MF;
          p_tag_d  = IN_TAG;
          p_data_d = IN_DATA;
          state_d  = S_CMP;
        end
      end

      S_CMP: begin
        hit_d   = |fire;
        full_d  = &valid_q;
        state_d = S_ACT;
      end

      S_ACT: begin
        state_d = S_IDLE;
        if (!p_mf_q) begin
          // bypass: controller strobes are don't-care here
          out_v_d    = 1'b1;
          out_tag_d  = p_tag_q;
          out_a_d    = '0;
          out_b_d    = p_data_q;
          out_pair_d = 1'b0;
        end else if (hit_q) begin
          // a hit without DEL leaves the store untouched and drops P
          if (DEL) begin
            valid_d[ADDR] = 1'b0;
            out_v_d       = 1'b1;
            out_tag_d     = p_tag_q;
            out_a_d       = data_mem[ADDR];
            out_b_d       = p_data_q;
            out_pair_d    = 1'b1;
          end
        end else if (full_q) begin
          ovf = 1'b1;
        end else if (WR_E) begin
          if (valid_q[ADDR]) begin
            // controller pointed at an occupied slot: refuse, flag it
            ovf = 1'b1;
          end else begin
            valid_d[ADDR] = 1'b1;
            mem_we        = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, P and result registers with asynchronous reset.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q    <= S_IDLE;
      p_mf_q     <= 1'b0;
      p_tag_q    <= '0;
      p_data_q   <= '0;
      hit_q      <= 1'b0;
      full_q     <= 1'b0;
      valid_q    <= '0;
      out_v_q    <= 1'b0;
      out_tag_q  <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_pair_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_mf_q     <= p_mf_d;
      p_tag_q    <= p_tag_d;
      p_data_q   <= p_data_d;
      hit_q      <= hit_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
      out_v_q    <= out_v_d;
      out_tag_q  <= out_tag_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_pair_q <= out_pair_d;
    end
  end

  // Tag/data array write; no reset needed since VALID gates every read.
  always_ff @(posedge CP) begin
    if (mem_we) begin
      tag_mem[ADDR]  <= p_tag_q;
      data_mem[ADDR] <= p_data_q;
    end
  end

  assign IN_RDY   = in_rdy;
  assign FIRE     = fire;
  assign VALID    = valid_q;
  assign MF       = (state_q == S_CMP) && p_mf_q;
  assign OVF      = ovf;
  assign OUT_V    = out_v_q;
  assign OUT_TAG  = out_tag_q;
  assign OUT_A    = out_a_q;
  assign OUT_B    = out_b_q;
  assign OUT_PAIR = out_pair_q;

endmodule

// File: doc/join_match_memory.md
JOIN_MATCH_MEMORY -- requirements
Module: join_match_memory

Interface
REQ-001 SHALL have parameter TAG_W, default 16, match-key width.
REQ-002 SHALL have parameter DATA_W, default 32, operand width; entry count fixed at 64.
REQ-003 SHALL have port CP  input  1  clock; all state updates on posedge CP.
REQ-004 SHALL have port MR  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports IN_V input 1, IN_RDY output 1  incoming-packet handshake; transfer when both high at posedge CP.
REQ-006 SHALL have ports IN_MF input 1, IN_TAG input TAG_W, IN_DATA input DATA_W  packet matching flag, key, operand.
REQ-007 SHALL have ports FIRE output 64, VALID output 64, MF output 1  match vector, occupancy, matching flag toward the allocation controller.
REQ-008 SHALL have ports WR_E input 1, DEL input 1, ADDR input 6  registered write strobe, delete strobe, entry address from the allocation controller.
REQ-009 SHALL have ports OUT_V output 1, OUT_RDY input 1  result handshake.
REQ-010 SHALL have ports OUT_TAG output TAG_W, OUT_A output DATA_W, OUT_B output DATA_W, OUT_PAIR output 1  key, stored operand, incoming operand, paired flag.
REQ-011 SHALL have port OVF output 1  one-cycle pulse, packet dropped because memory full.

Function
REQ-012 SHALL hold 64 entries {VALID[i], TAG[i], DATA[i]} plus one packet-hold register P {MF, TAG, DATA}.
REQ-013 SHALL implement FSM IDLE -> CMP -> ACT -> IDLE; CMP and ACT last exactly one cycle each.
REQ-014 IN_RDY SHALL be 1 only in IDLE with output register empty or draining (!OUT_V || OUT_RDY); accepted packet loads P and enters CMP.
REQ-015 In CMP: FIRE[i] = VALID[i] && TAG[i]==P.TAG && P.MF; MF = P.MF; outside CMP FIRE=0 and MF=0.
REQ-016 At CMP->ACT edge SHALL latch HIT = |FIRE and FULL = &VALID.
REQ-017 In ACT with P.MF=1, HIT=1, DEL=1: clear VALID[ADDR]; load output: OUT_TAG=P.TAG, OUT_A=DATA[ADDR], OUT_B=P.DATA, OUT_PAIR=1, OUT_V=1.
REQ-018 In ACT with P.MF=1, HIT=0, FULL=0, WR_E=1: write TAG[ADDR]=P.TAG, DATA[ADDR]=P.DATA, VALID[ADDR]=1; no output.
REQ-019 In ACT with P.MF=1, HIT=0, FULL=1: no entry change; OVF pulses 1 for that cycle; packet discarded.
REQ-020 In ACT with P.MF=0: bypass; OUT_TAG=P.TAG, OUT_A=0, OUT_B=P.DATA, OUT_PAIR=0, OUT_V=1; WR_E/DEL/ADDR ignored.
REQ-021 Write in ACT to an entry already VALID SHALL be ignored and pulse OVF (protocol error).
REQ-022 Multiple FIRE bits: only entry ADDR cleared; others untouched.
REQ-023 OUT_V SHALL stay high with outputs stable until OUT_RDY=1; cleared at that edge unless reloaded same edge.
REQ-024 Latency: accepted packet produces OUT_V two edges after acceptance (CMP, ACT) when output free.
REQ-025 VALID output SHALL reflect entry occupancy registers directly, in every state.

Reset
REQ-026 MR=1 SHALL immediately force: FSM=IDLE, VALID=0, P=0, FIRE=0, MF=0, IN_RDY=0, OUT_V=0, OUT_TAG/OUT_A/OUT_B=0, OUT_PAIR=0, OVF=0.
REQ-027 TAG/DATA arrays need not be reset; VALID=0 masks them.
REQ-028 MR mid-operation SHALL abort in-flight packet and pending output without OVF; IN_RDY=1 first cycle after MR falls.

Verification
REQ-029 Reset, packet MF=1 TAG=0x0005 DATA=0xAAAA0001 -> no OUT_V, VALID[0]=1 after ACT.
REQ-030 Then packet MF=1 TAG=0x0005 DATA=0x00000002 -> FIRE[0]=1 in CMP; OUT_V with OUT_A=0xAAAA0001, OUT_B=0x00000002, OUT_PAIR=1; VALID[0]=0.
REQ-031 Packet MF=0 TAG=0x0009 DATA=0x12345678 -> OUT_V, OUT_PAIR=0, OUT_A=0, OUT_B=0x12345678; VALID unchanged.
REQ-032 Fill 64 distinct tags, send 65th distinct tag -> OVF one-cycle pulse, VALID all ones, no OUT_V.
REQ-033 Hold OUT_RDY=0 after a pair result -> outputs stable, IN_RDY=0; raise OUT_RDY -> OUT_V falls, IN_RDY=1.
REQ-034 Assert MR during CMP -> FIRE=0, VALID=0, OUT_V=0 immediately; no OVF.
